mem_pkt_gen: RTL and testbench

MEM_PKT_GEN -- requirements
Module: mem_pkt_gen

---
 rtl/mem_pkt_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_pkt_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_pkt_gen.sv
// mem_pkt_gen: memory-test packet generator. Each start_i launches trans_cnt
// packets. Every packet carries a word address, a burst count and byte masks
// that are derived from the current byte address and the configured byte count.
// Optional feature: define MEM_PKT_GEN_RND_ADDR_EN to build the LFSR used by
// RND_ADDR. When it is left undefined, RND_ADDR behaves as FIX_ADDR.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_i; the config inputs are latched on start
// CALC  | register the pkt_* fields for the current address
// VALID | pkt_valid_o held high until pkt_ready_i
// DONE  | last packet accepted; done_o pulses on the way back to IDLE
module mem_pkt_gen #(
    parameter int ADDR_W      = 31,
    parameter int AMM_BURST_W = 11,
    parameter int DATA_B_W    = 16,
    parameter int TRANS_CNT_W = 16
) (
    input  logic                               clk_sys_i,
    input  logic                               rst_n_i,
    input  logic                               start_i,
    input  logic                               abort_i,
    input  logic [2:0]                         addr_mode_i,
    input  logic [ADDR_W-1:0]                  base_addr_i,
    input  logic [AMM_BURST_W+$clog2(DATA_B_W)-2:0] byte_cnt_i,
    input  logic [TRANS_CNT_W-1:0]             trans_cnt_i,
    input  logic [7:0]                         data_ptrn_i,
    input  logic                               data_ptrn_type_i,
    output logic                               pkt_valid_o,
    input  logic                               pkt_ready_i,
    output logic [ADDR_W-$clog2(DATA_B_W)-1:0] pkt_word_addr_o,
    output logic [AMM_BURST_W-1:0]             pkt_burst_cnt_o,
    output logic [DATA_B_W-1:0]                pkt_start_mask_o,
    output logic [DATA_B_W-1:0]                pkt_end_mask_o,
    output logic [7:0]                         pkt_data_ptrn_o,
    output logic                               pkt_data_ptrn_type_o,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int ADDR_B_W = $clog2(DATA_B_W);
    localparam int BC_W     = AMM_BURST_W + ADDR_B_W - 1;
    localparam int WA_W     = ADDR_W - ADDR_B_W;
    localparam int EXT_W    = (ADDR_W > BC_W) ? ADDR_W : BC_W;
    localparam int K_W      = $clog2(ADDR_W);

    localparam logic [2:0] M_FIX = 3'd0;
    localparam logic [2:0] M_RND = 3'd1;
    localparam logic [2:0] M_RUN0 = 3'd2;
    localparam logic [2:0] M_RUN1 = 3'd3;
    localparam logic [2:0] M_INC = 3'd4;

    localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_VALID = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [2:0]             mode_q;
    logic [BC_W-1:0]        byte_cnt_q;
    logic [TRANS_CNT_W-1:0] trans_cnt_q;
    logic [TRANS_CNT_W-1:0] cnt_q;
    logic [7:0]             ptrn_q;
    logic                   ptrn_type_q;
    logic [ADDR_W-1:0]      cur_addr_q;
    logic [K_W-1:0]         k_q;

    logic [BC_W-1:0]   eff_cnt;
    logic [ADDR_W-1:0] pkt_addr;
    logic [EXT_W-1:0]  end_ext;
    logic [EXT_W-1:0]  inc_ext;
    logic [ADDR_W-1:0] end_addr;
    logic [WA_W-1:0]   burst_full;
    logic              handshake;
    logic              last_pkt;

`ifdef MEM_PKT_GEN_RND_ADDR_EN
    logic [31:0] lfsr_q;
    logic [31:0] lfsr_next;

    // Right-shifting Galois step; the taps are folded in when bit 0 shifts out
    always_comb begin
        lfsr_next = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_next = (lfsr_q >> 1) ^ LFSR_TAPS;
        end
    end
`endif

    // Byte address of the packet being built, selected by the addressing mode
    always_comb begin
        pkt_addr = cur_addr_q;
        case (mode_q)
            M_RUN1: pkt_addr = ADDR_W'(1) << k_q;
            M_RUN0: pkt_addr = ~(ADDR_W'(1) << k_q);
`ifdef MEM_PKT_GEN_RND_ADDR_EN
            M_RND:  pkt_addr = lfsr_q[ADDR_W-1:0];
`endif
            default: pkt_addr = cur_addr_q;
        endcase
    end

    // Packet geometry: a zero byte count is treated as one byte
    always_comb begin
        eff_cnt    = (byte_cnt_q == '0) ? BC_W'(1) : byte_cnt_q;
        end_ext    = EXT_W'(pkt_addr) + EXT_W'(eff_cnt) - EXT_W'(1);
        inc_ext    = EXT_W'(cur_addr_q) + EXT_W'(eff_cnt);
        end_addr   = end_ext[ADDR_W-1:0];
        burst_full = end_addr[ADDR_W-1:ADDR_B_W] - pkt_addr[ADDR_W-1:ADDR_B_W] + WA_W'(1);
        handshake  = (state_q == S_VALID) && pkt_ready_i;
        last_pkt   = ((cnt_q + TRANS_CNT_W'(1)) == trans_cnt_q);
    end

    // State register
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over everything outside IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (trans_cnt_i == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC:  state_d = S_VALID;
            S_VALID: begin
                if (handshake) begin
                    state_d = last_pkt ? S_DONE : S_CALC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    assign busy_o = (state_q != S_IDLE);

    // Config latch, address sequencing and registered packet outputs
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_q               <= '0;
            byte_cnt_q           <= '0;
            trans_cnt_q          <= '0;
            cnt_q                <= '0;
            ptrn_q               <= '0;
            ptrn_type_q          <= 1'b0;
            cur_addr_q           <= '0;
            k_q                  <= '0;
`ifdef MEM_PKT_GEN_RND_ADDR_EN
            lfsr_q               <= LFSR_SEED;
`endif
            pkt_valid_o          <= 1'b0;
            pkt_word_addr_o      <= '0;
            pkt_burst_cnt_o      <= '0;
            pkt_start_mask_o     <= '0;
            pkt_end_mask_o       <= '0;
            pkt_data_ptrn_o      <= '0;
            pkt_data_ptrn_type_o <= 1'b0;
            done_o               <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q      <= addr_mode_i;
                        byte_cnt_q  <= byte_cnt_i;
                        trans_cnt_q <= trans_cnt_i;
                        ptrn_q      <= data_ptrn_i;
                        ptrn_type_q <= data_ptrn_type_i;
                        cur_addr_q  <= base_addr_i;
                        cnt_q       <= '0;
                        k_q         <= '0;
`ifdef MEM_PKT_GEN_RND_ADDR_EN
                        lfsr_q      <= LFSR_SEED;
`endif
                    end
                end
                S_CALC: begin
                    if (!abort_i) begin
                        pkt_valid_o          <= 1'b1;
                        pkt_word_addr_o      <= pkt_addr[ADDR_W-1:ADDR_B_W];
                        pkt_burst_cnt_o      <= AMM_BURST_W'(burst_full);
                        pkt_start_mask_o     <= {DATA_B_W{1'b1}} << pkt_addr[ADDR_B_W-1:0];
                        pkt_end_mask_o       <= {DATA_B_W{1'b1}} >> (~end_addr[ADDR_B_W-1:0]);
                        pkt_data_ptrn_o      <= ptrn_q;
                        pkt_data_ptrn_type_o <= ptrn_type_q;
                    end
                end
                S_VALID: begin
                    if (abort_i) begin
                        pkt_valid_o <= 1'b0;
                    end else if (pkt_ready_i) begin
                        pkt_valid_o <= 1'b0;
                        cnt_q       <= cnt_q + TRANS_CNT_W'(1);
                        k_q         <= (k_q == K_W'(ADDR_W - 1)) ? '0 : k_q + K_W'(1);
`ifdef MEM_PKT_GEN_RND_ADDR_EN
                        lfsr_q      <= lfsr_next;
`endif
                        if (mode_q == M_INC) begin
                            cur_addr_q <= inc_ext[ADDR_W-1:0];
                        end
                    end
                end
                S_DONE: begin
                    done_o <= !abort_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_pkt_gen.sv
// Bench for mem_pkt_gen with default parameters (16-byte words, 31-bit byte
// addresses). Expected packets are computed from the byte-address arithmetic.
module tb_mem_pkt_gen;

    localparam int  ADDR_W = 31;
    localparam int  AMM_BURST_W = 11;
    localparam int  DATA_B_W = 16;
    localparam int  TRANS_CNT_W = 16;
    localparam longint AMASK = (64'd1 << 31) - 1;

    logic        clk_sys_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [2:0]  addr_mode_i = '0;
    logic [30:0] base_addr_i = '0;
    logic [13:0] byte_cnt_i = '0;
    logic [15:0] trans_cnt_i = '0;
    logic [7:0]  data_ptrn_i = '0;
    logic        data_ptrn_type_i = 1'b0;
    logic        pkt_valid_o;
    logic        pkt_ready_i = 1'b0;
    logic [26:0] pkt_word_addr_o;
    logic [10:0] pkt_burst_cnt_o;
    logic [15:0] pkt_start_mask_o;
    logic [15:0] pkt_end_mask_o;
    logic [7:0]  pkt_data_ptrn_o;
    logic        pkt_data_ptrn_type_o;
    logic        busy_o;
    logic        done_o;

    mem_pkt_gen #(
        .ADDR_W(ADDR_W), .AMM_BURST_W(AMM_BURST_W),
        .DATA_B_W(DATA_B_W), .TRANS_CNT_W(TRANS_CNT_W)
    ) dut (
        .clk_sys_i(clk_sys_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
        .addr_mode_i(addr_mode_i), .base_addr_i(base_addr_i), .byte_cnt_i(byte_cnt_i),
        .trans_cnt_i(trans_cnt_i), .data_ptrn_i(data_ptrn_i),
        .data_ptrn_type_i(data_ptrn_type_i), .pkt_valid_o(pkt_valid_o),
        .pkt_ready_i(pkt_ready_i), .pkt_word_addr_o(pkt_word_addr_o),
        .pkt_burst_cnt_o(pkt_burst_cnt_o), .pkt_start_mask_o(pkt_start_mask_o),
        .pkt_end_mask_o(pkt_end_mask_o), .pkt_data_ptrn_o(pkt_data_ptrn_o),
        .pkt_data_ptrn_type_o(pkt_data_ptrn_type_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    longint ex_word[$];
    longint ex_burst[$];
    longint ex_sm[$];
    longint ex_em[$];

    // Reference: the byte address of packet i follows directly from the mode
    function automatic void build(input int mode, input longint base, input int bc, input int trans);
        longint eff, a, e;
        logic [31:0] lfsr;
        eff  = (bc == 0) ? 1 : bc;
        lfsr = 32'hACE12468;
        ex_word.delete(); ex_burst.delete(); ex_sm.delete(); ex_em.delete();
        for (int i = 0; i < trans; i++) begin
            case (mode)
                4: a = (base + longint'(i) * eff) & AMASK;
                3: a = longint'(1) << (i % 31);
                2: a = ~(longint'(1) << (i % 31)) & AMASK;
`ifdef MEM_PKT_GEN_RND_ADDR_EN
                1: begin
                    a = longint'(lfsr) & AMASK;
                    lfsr = lfsr[0] ? ((lfsr >> 1) ^ 32'h80200003) : (lfsr >> 1);
                end
`endif
                default: a = base;
            endcase
            e = (a + eff - 1) & AMASK;
            ex_word.push_back(a >> 4);
            ex_burst.push_back((((e >> 4) - (a >> 4) + 1) & ((longint'(1) << 27) - 1)) & 'h7FF);
            ex_sm.push_back((longint'('hFFFF) << (a & 15)) & 'hFFFF);
            ex_em.push_back(longint'('hFFFF) >> (15 - (e & 15)));
        end
    endfunction

    task automatic run(input string name, input int mode, input longint base, input int bc,
                       input int trans, input int stall, input int abort_pkt, input int ready_pct);
        int idx, dones, first_v, held;
        bit finished, expect_hold;
        logic [7:0] ptrn;
        logic       ptype;
        build(mode, base, bc, trans);
        idx = 0; dones = 0; first_v = -1; held = 0; finished = 0; expect_hold = 0;
        ptrn = 8'($urandom); ptype = 1'($urandom);
        @(negedge clk_sys_i);
        addr_mode_i = 3'(mode); base_addr_i = 31'(base); byte_cnt_i = 14'(bc);
        trans_cnt_i = 16'(trans); data_ptrn_i = ptrn; data_ptrn_type_i = ptype;
        start_i = 1'b1; pkt_ready_i = 1'b0;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk_sys_i);
            start_i = 1'b0;
            // scramble config inputs; only the values latched on start matter
            base_addr_i = 31'($urandom); byte_cnt_i = 14'($urandom);
            trans_cnt_i = 16'($urandom); addr_mode_i = 3'($urandom);
            data_ptrn_i = 8'($urandom); data_ptrn_type_i = 1'($urandom);
            if (cyc == 1) check({name, "/busy_after_start"}, 64'(busy_o), 1);
            if (expect_hold) check({name, "/valid_held"}, 64'(pkt_valid_o), 1);
            expect_hold = 0;
            if (done_o) begin
                dones++;
                if (trans == 0) check({name, "/done_latency"}, cyc, 2);
                finished = 1;
                break;
            end
            if (pkt_valid_o) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    check({name, "/first_valid_latency"}, cyc, 2);
                end
                if (idx < trans) begin
                    check({name, "/word"}, 64'(pkt_word_addr_o), ex_word[idx]);
                    check({name, "/burst"}, 64'(pkt_burst_cnt_o), ex_burst[idx]);
                    check({name, "/start_mask"}, 64'(pkt_start_mask_o), ex_sm[idx]);
                    check({name, "/end_mask"}, 64'(pkt_end_mask_o), ex_em[idx]);
                    check({name, "/ptrn"}, 64'(pkt_data_ptrn_o), 64'(ptrn));
                    check({name, "/ptrn_type"}, 64'(pkt_data_ptrn_type_o), 64'(ptype));
                end else begin
                    check({name, "/extra_packet"}, idx, trans - 1);
                end
                if (idx == abort_pkt) begin
                    abort_i = 1'b1; pkt_ready_i = 1'b1;
                    @(negedge clk_sys_i);
                    abort_i = 1'b0; pkt_ready_i = 1'b0;
                    check({name, "/abort_valid"}, 64'(pkt_valid_o), 0);
                    check({name, "/abort_busy"}, 64'(busy_o), 0);
                    repeat (6) begin
                        if (done_o) dones++;
                        @(negedge clk_sys_i);
                    end
                    check({name, "/abort_no_done"}, dones, 0);
                    check({name, "/abort_no_valid"}, 64'(pkt_valid_o), 0);
                    return;
                end
                if (idx == 0 && held < stall) begin
                    pkt_ready_i = 1'b0;
                    held++;
                end else begin
                    pkt_ready_i = ($urandom_range(99) < ready_pct);
                end
                if (pkt_ready_i) idx++;
                else expect_hold = 1;
                start_i = ($urandom_range(7) == 0);
            end else begin
                pkt_ready_i = 1'($urandom_range(1));
            end
        end
        check({name, "/completed_in_time"}, 64'(finished), 1);
        check({name, "/packets"}, idx, trans);
        check({name, "/done_count"}, dones, 1);
        if (trans == 0) check({name, "/no_valid"}, 64'(first_v < 0), 1);
        if (stall > 0) check({name, "/stall_cycles"}, held, stall);
        @(negedge clk_sys_i);
        pkt_ready_i = 1'b0;
        check({name, "/done_one_cycle"}, 64'(done_o), 0);
        check({name, "/idle_after_done"}, 64'(busy_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1;
        check("reset/valid", 64'(pkt_valid_o), 0);
        check("reset/busy", 64'(busy_o), 0);
        check("reset/done", 64'(done_o), 0);
        check("reset/word", 64'(pkt_word_addr_o), 0);
        check("reset/masks", {32'(pkt_start_mask_o), 32'(pkt_end_mask_o)}, 0);
        repeat (3) @(negedge clk_sys_i);
        rst_n_i = 1'b1;

        run("inc_basic", 4, 'h5, 40, 2, 0, -1, 100);
        run("fix_top", 0, 'h7FFFFFF8, 16, 1, 0, -1, 100);
        run("run1_wrap", 3, longint'($urandom) & AMASK, 1, 33, 0, -1, 100);
        run("run0", 2, longint'($urandom) & AMASK, 20, 33, 0, -1, 60);
        run("stall5", 4, 'h5, 40, 2, 5, -1, 100);
        run("abort_p3", 4, 'h100, 64, 10, 0, 3, 100);
        run("trans_zero", 4, 'h100, 64, 0, 0, -1, 100);
        run("bc_zero", 4, 'h7FFFFFFE, 0, 4, 0, -1, 70);
        run("inc_wrap", 4, 'h7FFFFFF0, 300, 3, 0, -1, 70);
        run("rnd_mode", 1, 'h1234567, 33, 5, 0, -1, 70);
        run("other_code", 6, 'h3003, 17, 3, 0, -1, 70);

        for (int t = 0; t < 12; t++) begin
            run($sformatf("rand%0d", t), int'($urandom_range(7)), longint'($urandom) & AMASK,
                ($urandom_range(3) == 0) ? 0 : int'($urandom_range(16383)),
                int'($urandom_range(1, 12)), 0, -1, 50);
        end

        // reset in the middle of a test: nothing resumes without a new start
        @(negedge clk_sys_i);
        addr_mode_i = 3'd4; base_addr_i = 31'h40; byte_cnt_i = 14'd32; trans_cnt_i = 16'd10;
        start_i = 1'b1; pkt_ready_i = 1'b0;
        @(negedge clk_sys_i);
        start_i = 1'b0;
        repeat (2) @(negedge clk_sys_i);
        check("midreset/valid_before", 64'(pkt_valid_o), 1);
        #2 rst_n_i = 1'b0;
        #1;
        check("midreset/valid_async", 64'(pkt_valid_o), 0);
        check("midreset/busy_async", 64'(busy_o), 0);
        @(negedge clk_sys_i);
        rst_n_i = 1'b1;
        pkt_ready_i = 1'b1;
        repeat (5) @(negedge clk_sys_i);
        check("midreset/no_resume_valid", 64'(pkt_valid_o), 0);
        check("midreset/no_resume_busy", 64'(busy_o), 0);
        pkt_ready_i = 1'b0;

        run("after_reset", 4, 'h5, 40, 2, 0, -1, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
